// File: rtl/a2d_intf.sv
// a2d_intf: SPI master for the A2D converter. Each conversion runs two identical
// 16-bit frames separated by a gap; the channel result returns in the second frame.
// Optional build macro A2D_RES_INV_EN: when defined, res loads the inverted data
// (reflective IR sensors read high when dark).
module a2d_intf #(
    parameter int SCLK_PER = 32            // clk cycles per SCLK period (even, >= 8)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic [11:0] res,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int FRAME_LEN = 16 * SCLK_PER + 32;
    localparam int CW        = $clog2(FRAME_LEN);
    localparam int PW        = $clog2(SCLK_PER);

    // Frame positions: 16-clk front porch, 16 SCLK periods, 16-clk back porch.
    localparam logic [CW-1:0] LAST_POS  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] ACT_START = CW'(16);
    localparam logic [CW-1:0] ACT_END   = CW'(16 + 16 * SCLK_PER);  // first back-porch clk
    localparam logic [CW-1:0] GAP_LAST  = CW'(SCLK_PER - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(SCLK_PER - 1);
    localparam logic [PW-1:0] PH_RISE   = PW'(SCLK_PER / 2);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] XFER1 = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] XFER2 = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;          // clk index inside the current frame or gap
    logic [PW-1:0] ph;           // phase inside the current SCLK period
    logic [15:0]   shift;
    logic [2:0]    chnnl_lat;
    logic          miso_smp;

    logic [CW-1:0] pos_nxt;
    logic [PW-1:0] ph_nxt;
    logic          act_nxt;
    logic          rise_nxt;
    logic          shift_en;
    logic [11:0]   res_load;

    assign MOSI = shift[15];

`ifdef A2D_RES_INV_EN
    assign res_load = ~shift[11:0];
`else
    assign res_load = shift[11:0];
`endif

    // Look ahead one clk: where the frame will be next cycle and what SCLK does there.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pos_nxt  = cnt + 1'b1;
        act_nxt  = 1'b0;
        ph_nxt   = '0;
        rise_nxt = 1'b0;
        shift_en = 1'b0;
        act_nxt  = (pos_nxt >= ACT_START) && (pos_nxt < ACT_END);
        if (act_nxt) begin
            ph_nxt   = ((pos_nxt == ACT_START) || (ph == PH_LAST)) ? '0 : ph + 1'b1;
            rise_nxt = (ph_nxt == PH_RISE);
        end
        // Shift on every SCLK fall except the first; bit 16 shifts on the first back-porch clk.
        shift_en = (act_nxt && (ph_nxt == '0) && (pos_nxt != ACT_START))
                 || (pos_nxt == ACT_END);
    end

    // Conversion sequencer: state, frame timing, SPI pins, shift register and result.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ph        <= '0;
            shift     <= '0;
            chnnl_lat <= '0;
            miso_smp  <= 1'b0;
            res       <= '0;
            cnv_cmplt <= 1'b0;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (strt_cnv) begin
                        state     <= XFER1;
                        chnnl_lat <= chnnl;
                        cnv_cmplt <= 1'b0;
                        cnt       <= '0;
                        ph        <= '0;
                        SS_n      <= 1'b0;
                        SCLK      <= 1'b1;
                        shift     <= {2'b00, chnnl, 11'h000};
                    end
                end
                XFER1, XFER2: begin
                    if (cnt == LAST_POS) begin
                        cnt  <= '0;
                        ph   <= '0;
                        SS_n <= 1'b1;
                        SCLK <= 1'b1;
                        if (state == XFER1) begin
                            state <= GAP;
                        end else begin
                            state     <= DONE;
                            res       <= res_load;
                            cnv_cmplt <= 1'b1;
                        end
                    end else begin
                        cnt  <= pos_nxt;
                        ph   <= ph_nxt;
                        SCLK <= act_nxt ? (ph_nxt >= PH_RISE) : 1'b1;
                        if (rise_nxt) miso_smp <= MISO;
                        if (shift_en) shift <= {shift[14:0], miso_smp};
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= XFER2;
                        cnt   <= '0;
                        SS_n  <= 1'b0;
                        shift <= {2'b00, chnnl_lat, 11'h000};
                    end else begin
                        cnt <= pos_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    SS_n  <= 1'b1;
                    SCLK  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// Testbench for a2d_intf at the default SCLK_PER. A small ADC model serves MISO
// (changing on SCLK falls) and records MOSI and the SCLK fall count of each frame.
module tb_a2d_intf;

    localparam int XF1_END = 544;
    localparam int GAP_END = 576;
    localparam int XF2_END = 1120;
    localparam int CMPLT   = 1121;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] res;
    logic        cnv_cmplt;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    a2d_intf dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .res       (res),
        .cnv_cmplt (cnv_cmplt),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    // ADC model state: written only by the model processes below
    int          frame_cnt   = 0;
    int          fall_cnt    = 0;
    int          stray_falls = 0;
    logic [15:0] mosi_sr     = '0;
    logic [15:0] adc_word    = '0;
    int          frame_falls [3];
    logic [15:0] frame_mosi  [3];
    // Written only by the stimulus process
    int          frame_base  = 0;
    logic [15:0] adc_result  = '0;

    always @(negedge SS_n) begin
        frame_cnt = frame_cnt + 1;
        fall_cnt  = 0;
        mosi_sr   = '0;
        adc_word  = ((frame_cnt - frame_base) == 2) ? adc_result : 16'hC3A5;
    end

    always @(negedge SCLK) begin
        if (!SS_n) begin
            if (fall_cnt < 16) MISO = adc_word[15 - fall_cnt];
            fall_cnt = fall_cnt + 1;
        end else begin
            stray_falls = stray_falls + 1;
        end
    end

    always @(posedge SCLK) begin
        if (!SS_n) mosi_sr = {mosi_sr[14:0], MOSI};
    end

    always @(posedge SS_n) begin
        if ((frame_cnt - frame_base) >= 1 && (frame_cnt - frame_base) <= 2) begin
            frame_falls[frame_cnt - frame_base] = fall_cnt;
            frame_mosi[frame_cnt - frame_base]  = mosi_sr;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt = pass_cnt + 1;
    endtask

    typedef struct {
        logic [2:0]  ch;
        logic [15:0] word;       // ADC reply in the second frame
        logic [15:0] frame;      // expected MOSI frame
        logic [11:0] res_plain;
        logic [11:0] res_inv;
        bit          retrig;     // re-pulse strt_cnv at cycles 100, 600 and 1120
    } vec_t;

    vec_t vecs[4];

    // Caller is at a negedge in cycle 0; returns at a negedge with strt_cnv low.
    task automatic run_conv(input vec_t v);
        logic [11:0] res_before;
        logic [11:0] exp_res;
        int ss_err = 0, sclk_err = 0, cc_err = 0, hold_err = 0, post_err = 0;
        int stray0;
        bit exp_ss;
`ifdef A2D_RES_INV_EN
        exp_res = v.res_inv;
`else
        exp_res = v.res_plain;
`endif
        res_before  = res;
        frame_base  = frame_cnt;
        adc_result  = v.word;
        stray0      = stray_falls;
        frame_falls[1] = -1;
        frame_falls[2] = -1;
        chnnl    = v.ch;
        strt_cnv = 1'b1;
        for (int n = 1; n <= CMPLT; n++) begin
            @(negedge clk);
            exp_ss = !((n <= XF1_END) || (n > GAP_END && n <= XF2_END));
            if (SS_n !== exp_ss) ss_err++;
            if (SS_n && !SCLK) sclk_err++;
            if (cnv_cmplt !== (n == CMPLT)) cc_err++;
            if (n < CMPLT && res !== res_before) hold_err++;
            strt_cnv = 1'b0;
            chnnl    = ~v.ch;
            if (v.retrig && (n == 100 || n == 600 || n == 1120)) strt_cnv = 1'b1;
        end
        check("ss_n_timing",  ss_err,   0);
        check("sclk_idle",    sclk_err, 0);
        check("cmplt_timing", cc_err,   0);
        check("res_hold",     hold_err, 0);
        check("res_value",    res,      exp_res);
        check("falls_xfer1",  frame_falls[1], 16);
        check("falls_xfer2",  frame_falls[2], 16);
        check("mosi_xfer1",   frame_mosi[1],  v.frame);
        check("mosi_xfer2",   frame_mosi[2],  v.frame);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!SS_n || !SCLK || !cnv_cmplt || res !== exp_res) post_err++;
        end
        check("done_stable",  post_err, 0);
        check("stray_falls",  stray_falls - stray0, 0);
    endtask

    initial begin
        int quiet_err;

        //        ch     word      frame     plain    inv      retrig
        vecs[0] = '{3'd5, 16'h0ABC, 16'h2800, 12'hABC, 12'h543, 1'b1};
        vecs[1] = '{3'd0, 16'h0123, 16'h0000, 12'h123, 12'hEDC, 1'b0};
        vecs[2] = '{3'd7, 16'h0FED, 16'h3800, 12'hFED, 12'h012, 1'b0};
        vecs[3] = '{3'd2, 16'hF800, 16'h1000, 12'h800, 12'h7FF, 1'b0};

        rst = 1'b1; strt_cnv = 1'b0; chnnl = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_ss_n",  SS_n,      1);
        check("rst_sclk",  SCLK,      1);
        check("rst_mosi",  MOSI,      0);
        check("rst_res",   res,       0);
        check("rst_cmplt", cnv_cmplt, 0);
        rst = 1'b0;

        quiet_err = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!SS_n || !SCLK || cnv_cmplt) quiet_err++;
        end
        check("idle_quiet", quiet_err, 0);

        // Back-to-back conversions; every one after the first starts from DONE
        for (int i = 0; i < 4; i++) run_conv(vecs[i]);

        // Reset in the middle of XFER1
        frame_base = frame_cnt;
        chnnl = 3'd6; strt_cnv = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            strt_cnv = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ss_n",  SS_n,      1);
        check("midrst_sclk",  SCLK,      1);
        check("midrst_cmplt", cnv_cmplt, 0);
        check("midrst_res",   res,       0);
        check("midrst_mosi",  MOSI,      0);
        rst = 1'b0;
        quiet_err = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!SS_n || !SCLK) quiet_err++;
        end
        check("midrst_quiet", quiet_err, 0);

        // Normal conversion after the mid-transfer reset
        run_conv(vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 SHALL have parameter SCLK_PER, default 32, meaning clk cycles per SCLK period (even, >=8).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset sampled on rising clk.
REQ-004 SHALL have port strt_cnv, input, 1, a one-cycle request to start a conversion.
REQ-005 SHALL have port chnnl, input, 3, the ADC channel to convert, latched on an accepted strt_cnv.
REQ-006 SHALL have port res, output, 12, the conversion result of the last completed conversion.
REQ-007 SHALL have port cnv_cmplt, output, 1, which is high when res is valid for the last request.
REQ-008 SHALL have port SS_n, output, 1, the active-low ADC slave select.
REQ-009 SHALL have port SCLK, output, 1, the SPI serial clock; it idles high.
REQ-010 SHALL have port MOSI, output, 1, SPI data to the ADC.
REQ-011 SHALL have port MISO, input, 1, SPI data from the ADC.

Function
REQ-012 SHALL act as the responder to the motion controller's conversion request: request is strt_cnv plus chnnl, and the response is cnv_cmplt plus res.
REQ-013 SHALL implement states IDLE, XFER1, GAP, XFER2 and DONE.
REQ-014 From IDLE or DONE, strt_cnv SHALL latch chnnl, clear cnv_cmplt, and enter XFER1 next cycle.
REQ-015 strt_cnv in XFER1, GAP or XFER2 SHALL be ignored, with no restart and no relatch.
REQ-016 Each transaction (XFER1, XFER2) SHALL hold SS_n low for exactly 16*SCLK_PER+32 clks (544 at default).
- Sequence: 16 clk front porch with SCLK high.
- Then 16 SCLK periods, each SCLK_PER/2 low followed by SCLK_PER/2 high.
- Then 16 clk back porch with SCLK high.
REQ-017 GAP SHALL hold SS_n high and SCLK high for exactly SCLK_PER clks.
REQ-018 XFER1 frame, MSB first, SHALL be {2'b00, chnnl_latched, 11'h000}.
REQ-019 XFER2 frame SHALL be identical to XFER1. The ADC returns the addressed channel's result in this second frame.
REQ-020 MOSI SHALL equal shift-register bit 15.
REQ-021 SCLK rising edges:
- MISO SHALL be captured on the clk where SCLK rises.
- The 16-bit shift register SHALL shift left, inserting the captured bit, on the next SCLK fall.
- For bit 16 the shift SHALL occur at the first back-porch clk.
- MOSI therefore changes only while SCLK is low or at frame end.
REQ-022 At end of XFER2, res SHALL load shift[11:0], cnv_cmplt SHALL go high, and the state SHALL become DONE.
REQ-023 Timing from strt_cnv sampled in cycle 0, at default parameter:
- SS_n low over cycles 1..544.
- SS_n high over cycles 545..576.
- SS_n low over cycles 577..1120.
- res and cnv_cmplt valid from cycle 1121.
REQ-024 cnv_cmplt SHALL stay high in DONE until the next accepted strt_cnv. res SHALL hold its value until the next completion.
REQ-025 strt_cnv in the same cycle as completion SHALL be ignored, because the state is not yet DONE.
REQ-026 Bit and SCLK counters SHALL wrap cleanly with no extra SCLK edge, and exactly 16 falling edges SHALL occur per transaction.

Reset
REQ-027 rst SHALL force the following on the next clk, in any state including mid-transaction:
- state IDLE
- SS_n=1, SCLK=1, MOSI=0
- res=12'h000, cnv_cmplt=0
- shift register and counters cleared
REQ-028 After reset deasserts, no SPI activity SHALL occur until strt_cnv.

Configuration
REQ-029 Macro A2D_RES_INV_EN, when defined, SHALL make res load ~shift[11:0] (reflective IR sensors read high when dark).
REQ-030 When A2D_RES_INV_EN is undefined, res SHALL load shift[11:0] unmodified. No other behaviour SHALL differ.

Verification
REQ-031 After rst, pulse strt_cnv with chnnl=3'b101 -> MOSI bits in both frames are 0010_1000_0000_0000; exactly 16 SCLK falls per frame; SS_n timing per REQ-023.
REQ-032 ADC model returns 16'h0ABC in XFER2 -> res=12'hABC and cnv_cmplt high from cycle 1121; with A2D_RES_INV_EN, res=12'h543.
REQ-033 strt_cnv repulsed at cycles 100 and 600 with a different chnnl -> ignored; frames still carry the original channel; a single completion at 1121.
REQ-034 rst asserted at cycle 300 of XFER1 -> next cycle SS_n=1, SCLK=1, cnv_cmplt=0, res=0; a new strt_cnv converts normally.
REQ-035 Back-to-back strt_cnv in DONE with chnnl 0 then 7 -> cnv_cmplt drops the cycle after request, second result correct, res unchanged until second completion.
